// File: rtl/data_mem_unit.sv
// data_mem_unit: wait-stated byte-addressable data memory with little-endian byte/half/word access.
// MemReady is a registered pulse in the cycle after RESP, so a response lands WAIT_CYCLES+1 cycles after acceptance.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        init,
  input  logic        MemReq,
  input  logic [31:0] AddressBusB,
  input  logic [31:0] DataBusOut,
  input  logic [3:0]  ContralBus,
  output logic [31:0] DataBusInB,
  output logic        MemReady,
  output logic        MemErr
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, ctl_q, ctl, lanes;
  logic [31:0] addr_q, wdata_q, addr, wdata, word, shifted, wd, bmask, rdata, data_q;
  logic idle, enter, err, err_q, rdy_q;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    enter = 1'b0;
    if (state_q == IDLE && MemReq) begin
      enter = WAIT_CYCLES == 0;
      state_d = enter ? RESP : WAIT;
      cnt_d = 4'(WAIT_CYCLES);
    end else if (state_q == WAIT) begin
      enter = cnt_q == 4'd1;
      state_d = enter ? RESP : WAIT;
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  // With zero wait states the access happens on the accept edge, so use the live inputs then.
  assign idle  = state_q == IDLE;
  assign addr  = idle ? AddressBusB : addr_q;
  assign wdata = idle ? DataBusOut : wdata_q;
  assign ctl   = idle ? ContralBus : ctl_q;
  assign err   = (ctl[2] & ctl[1]) | (!ctl[1] & (ctl[2] ? addr[0] : |addr[1:0]))
               | (addr[31:2] >= 30'(DEPTH_WORDS));
  assign idx   = addr[AW+1:2];
  assign lanes = ctl[1] ? 4'b0001 << addr[1:0] : ctl[2] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hF;
  assign bmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  assign wd    = ctl[1] ? {4{wdata[7:0]}} : ctl[2] ? {2{wdata[15:0]}} : wdata;
  assign word  = mem[idx];
  assign shifted = word >> {addr[1:0], 3'b000};
  assign rdata = ctl[1] ? {{24{ctl[0] & shifted[7]}}, shifted[7:0]}
               : ctl[2] ? {{16{ctl[0] & shifted[15]}}, shifted[15:0]} : word;
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      ctl_q <= 4'd0;
      data_q <= 32'd0;
      err_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdy_q <= state_q == RESP;
      if (idle && MemReq) begin
        addr_q <= AddressBusB;
        wdata_q <= DataBusOut;
        ctl_q <= ContralBus;
      end
      if (enter) begin
        err_q <= err;
        if (err) data_q <= 32'd0;
        else if (!ctl[3]) data_q <= rdata;
      end
    end
  end
  // The array is deliberately outside the reset; init still blocks a write landing on the same edge.
  always_ff @(posedge clk)
    if (enter && !err && ctl[3] && !init) mem[idx] <= (word & ~bmask) | (wd & bmask);
  assign DataBusInB = data_q;
  assign MemReady = rdy_q;
  assign MemErr = err_q;
endmodule
